// File: rtl/party_tone_mixer.sv
// Multi-channel square-wave tone generator whose volumes are summed into a PWM DAC.
// Build macro TONE_MIXER_NOISE_EN turns channel 0 into a 15-bit LFSR noise source.
module party_tone_mixer #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 12,
    parameter int VOL_W    = 4,
    parameter int TICK_DIV = 16,
    localparam int MIX_W   = (CHANNELS > 1) ? (VOL_W + $clog2(CHANNELS)) : (VOL_W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [VOL_W-1:0]    wr_vol,
    output logic [CHANNELS-1:0] phase_out,
    output logic [MIX_W-1:0]    mix_out,
    output logic                pwm_out
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]                   presc_q, presc_d;
    logic                               tick_s;
    logic                               wr_hit_s;
    logic [CHANNELS-1:0][PERIOD_W-1:0]  period_q, period_d;
    logic [CHANNELS-1:0][PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0][VOL_W-1:0]     vol_q, vol_d;
    logic [CHANNELS-1:0]                phase_q, phase_d;
    logic [CHANNELS-1:0]                reload_s;
    logic [MIX_W-1:0]                   mix_s;
    logic [MIX_W-1:0]                   mix_q, mix_d;
    logic [MIX_W-1:0]                   pwm_cnt_q, pwm_cnt_d;
    logic                               pwm_q, pwm_d;

`ifdef TONE_MIXER_NOISE_EN
    logic [14:0] lfsr_q, lfsr_d;

    // Fibonacci shift for x^15 + x^14 + 1; the new feedback bit lands in bit 0.
    function automatic logic [14:0] lfsr_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction
`endif

    // Prescaler: the tick fires in the last count so channels update on the wrap edge.
    always_comb begin
        tick_s = (presc_q == PRE_W'(TICK_DIV - 1));
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    // Write decode: out-of-range addresses are dropped without touching any channel.
    always_comb begin
        wr_hit_s = wr_en & ({1'b0, wr_addr} < 4'(CHANNELS));
    end

    // Per-channel tone state; a write overrides any tick reload in the same cycle.
    always_comb begin
        period_d = period_q;
        vol_d    = vol_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        reload_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit_s && (wr_addr == 3'(i))) begin
                period_d[i] = wr_period;
                vol_d[i]    = wr_vol;
                cnt_d[i]    = wr_period;
                if (wr_period == '0) begin
                    phase_d[i] = 1'b0;
                end else begin
                    phase_d[i] = phase_q[i];
                end
            end else if (period_q[i] == '0) begin
                cnt_d[i]   = '0;
                phase_d[i] = 1'b0;
            end else if (tick_s) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i]    = period_q[i];
                    phase_d[i]  = ~phase_q[i];
                    reload_s[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - PERIOD_W'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
`ifdef TONE_MIXER_NOISE_EN
        // Channel 0 phase comes from the LFSR, which only advances on its reloads.
        if (reload_s[0]) begin
            lfsr_d     = lfsr_step(lfsr_q);
            phase_d[0] = lfsr_d[0];
        end else begin
            lfsr_d = lfsr_q;
        end
`endif
    end

    // Unsaturated sum of the volumes of every channel currently high.
    always_comb begin
        mix_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (phase_q[i]) begin
                mix_s = mix_s + MIX_W'(vol_q[i]);
            end else begin
                mix_s = mix_s;
            end
        end
    end

    // PWM: sample the mix only at the start of a PWM frame so each frame has one duty.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + MIX_W'(1);
        if (pwm_cnt_q == '0) begin
            mix_d = mix_s;
        end else begin
            mix_d = mix_q;
        end
        pwm_d = (pwm_cnt_q < mix_d);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            period_q  <= '0;
            vol_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= '0;
            mix_q     <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
`ifdef TONE_MIXER_NOISE_EN
            lfsr_q    <= 15'h4000;
`endif
        end else begin
            presc_q   <= presc_d;
            period_q  <= period_d;
            vol_q     <= vol_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            mix_q     <= mix_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
`ifdef TONE_MIXER_NOISE_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign phase_out = phase_q;
    assign mix_out   = mix_q;
    assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_party_tone_mixer.sv
// Directed self-checking bench for party_tone_mixer at default parameters (MIX_W = 6).
module tb_party_tone_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [11:0] wr_period = 12'd0;
    logic [3:0]  wr_vol = 4'd0;
    logic [3:0]  phase_out;
    logic [5:0]  mix_out;
    logic        pwm_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ecnt = 0;

    party_tone_mixer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_period (wr_period),
        .wr_vol    (wr_vol),
        .phase_out (phase_out),
        .mix_out   (mix_out),
        .pwm_out   (pwm_out)
    );

    always #5 clk = ~clk;

    // Edge index since the last synchronous-looking reset release (edge 1 = first edge out of reset).
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
        $fatal(1);
    end

    task automatic goto_edge(input int n);
        int guard;
        guard = 0;
        while (ecnt < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt != n) begin
            total_cnt++;
            $display("FAIL goto_edge: at edge %0d, wanted %0d", ecnt, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_ch(input logic [2:0] a, input logic [11:0] p, input logic [3:0] v);
        wr_en = 1'b1;
        wr_addr = a;
        wr_period = p;
        wr_vol = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_period = 12'd1; wr_vol = 4'd15;
        @(negedge clk);
        total_cnt++; if (phase_out !== 4'b0000) $display("FAIL rst_phase: got %b want 0000", phase_out); else pass_cnt++;
        total_cnt++; if (mix_out !== 6'd0) $display("FAIL rst_mix: got %0d want 0", mix_out); else pass_cnt++;
        total_cnt++; if (pwm_out !== 1'b0) $display("FAIL rst_pwm: got %b want 0", pwm_out); else pass_cnt++;
        rst = 1'b0;
        wr_en = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (phase_out !== 4'b0000 || mix_out !== 6'd0 || pwm_out !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL idle_1000: %0d nonzero cycles, want 0", bad); else pass_cnt++;
    endtask

    task automatic test_square();
        int hi;
        do_reset();
        write_ch(3'd1, 12'd3, 4'd15);
        goto_edge(63);
        total_cnt++; if (phase_out !== 4'b0000) $display("FAIL sq_before_rise: got %b want 0000", phase_out); else pass_cnt++;
        goto_edge(64);
        total_cnt++; if (phase_out !== 4'b0010) $display("FAIL sq_rise: got %b want 0010", phase_out); else pass_cnt++;
        total_cnt++; if (mix_out !== 6'd0) $display("FAIL sq_mix_hold: got %0d want 0", mix_out); else pass_cnt++;
        goto_edge(65);
        total_cnt++; if (mix_out !== 6'd15) $display("FAIL sq_mix_15: got %0d want 15", mix_out); else pass_cnt++;
        total_cnt++; if (pwm_out !== 1'b1) $display("FAIL sq_pwm_start: got %b want 1", pwm_out); else pass_cnt++;
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            if (i != 0) @(negedge clk);
            if (pwm_out === 1'b1) hi++;
        end
        total_cnt++; if (hi != 15) $display("FAIL sq_duty: got %0d high of 64 want 15", hi); else pass_cnt++;
        total_cnt++; if (phase_out !== 4'b0000) $display("FAIL sq_fall: got %b want 0000", phase_out); else pass_cnt++;
        goto_edge(129);
        total_cnt++; if (mix_out !== 6'd0) $display("FAIL sq_mix_0: got %0d want 0", mix_out); else pass_cnt++;
    endtask

    task automatic test_all_channels();
        int hi;
        do_reset();
        goto_edge(16);
        for (int c = 0; c < 4; c++) write_ch(3'(c), 12'd1, 4'd15);
        goto_edge(47);
        total_cnt++; if (phase_out !== 4'b0000) $display("FAIL all_before: got %b want 0000", phase_out); else pass_cnt++;
        goto_edge(48);
        total_cnt++; if (phase_out !== 4'b1111) $display("FAIL all_rise: got %b want 1111", phase_out); else pass_cnt++;
        goto_edge(65);
        total_cnt++; if (mix_out !== 6'd60) $display("FAIL all_mix: got %0d want 60", mix_out); else pass_cnt++;
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            if (i != 0) @(negedge clk);
            if (pwm_out === 1'b1) hi++;
        end
        total_cnt++; if (hi != 60) $display("FAIL all_duty: got %0d high of 64 want 60", hi); else pass_cnt++;
        goto_edge(129);
        total_cnt++; if (mix_out !== 6'd60) $display("FAIL all_mix2: got %0d want 60", mix_out); else pass_cnt++;
    endtask

    task automatic test_ignore_and_silence();
        int bad2;
        write_ch(3'd5, 12'd7, 4'd9);
        goto_edge(143);
        total_cnt++; if (phase_out !== 4'b1111) $display("FAIL ign_phase_hi: got %b want 1111", phase_out); else pass_cnt++;
        goto_edge(144);
        total_cnt++; if (phase_out !== 4'b0000) $display("FAIL ign_phase_lo: got %b want 0000", phase_out); else pass_cnt++;
        goto_edge(193);
        total_cnt++; if (mix_out !== 6'd60) $display("FAIL ign_mix: got %0d want 60", mix_out); else pass_cnt++;
        goto_edge(194);
        write_ch(3'd2, 12'd0, 4'd15);
        total_cnt++; if (phase_out !== 4'b1011) $display("FAIL sil_next: got %b want 1011", phase_out); else pass_cnt++;
        bad2 = 0;
        while (ecnt < 330) begin
            @(negedge clk);
            if (phase_out[2] !== 1'b0) bad2++;
            if (ecnt == 208) begin
                total_cnt++; if (phase_out !== 4'b0000) $display("FAIL sil_e208: got %b want 0000", phase_out); else pass_cnt++;
            end
            if (ecnt == 240) begin
                total_cnt++; if (phase_out !== 4'b1011) $display("FAIL sil_e240: got %b want 1011", phase_out); else pass_cnt++;
            end
            if (ecnt == 257) begin
                total_cnt++; if (mix_out !== 6'd45) $display("FAIL sil_mix: got %0d want 45", mix_out); else pass_cnt++;
            end
        end
        total_cnt++; if (bad2 != 0) $display("FAIL sil_stays0: %0d cycles with ch2 high, want 0", bad2); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int bad;
        goto_edge(330);
        total_cnt++; if (phase_out !== 4'b1011) $display("FAIL pre_async: got %b want 1011", phase_out); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (phase_out !== 4'b0000) $display("FAIL async_phase: got %b want 0000", phase_out); else pass_cnt++;
        total_cnt++; if (mix_out !== 6'd0) $display("FAIL async_mix: got %0d want 0", mix_out); else pass_cnt++;
        total_cnt++; if (pwm_out !== 1'b0) $display("FAIL async_pwm: got %b want 0", pwm_out); else pass_cnt++;
        #1;
        rst = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (phase_out !== 4'b0000 || mix_out !== 6'd0 || pwm_out !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL async_quiet: %0d nonzero cycles want 0", bad); else pass_cnt++;
    endtask

    task automatic test_ch0();
        do_reset();
        write_ch(3'd0, 12'd1, 4'd1);
        goto_edge(32);
        total_cnt++; if (phase_out !== 4'b0001) $display("FAIL ch0_e32: got %b want 0001", phase_out); else pass_cnt++;
        goto_edge(64);
        total_cnt++; if (phase_out[0] !== 1'b0) $display("FAIL ch0_e64: got %b want 0", phase_out[0]); else pass_cnt++;
        goto_edge(96);
`ifdef TONE_MIXER_NOISE_EN
        total_cnt++; if (phase_out[0] !== 1'b0) $display("FAIL noise_e96: got %b want 0", phase_out[0]); else pass_cnt++;
        goto_edge(479);
        total_cnt++; if (phase_out[0] !== 1'b0) $display("FAIL noise_e479: got %b want 0", phase_out[0]); else pass_cnt++;
        goto_edge(480);
        total_cnt++; if (phase_out[0] !== 1'b1) $display("FAIL noise_e480: got %b want 1", phase_out[0]); else pass_cnt++;
`else
        total_cnt++; if (phase_out[0] !== 1'b1) $display("FAIL ch0_e96: got %b want 1", phase_out[0]); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_square();
        test_all_channels();
        test_ignore_and_silence();
        test_async_reset();
        test_ch0();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/party_tone_mixer.md
PARTY_TONE_MIXER -- requirements
Module: party_tone_mixer

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, number of tone channels (1..8).
REQ-002 SHALL provide parameter PERIOD_W, default 12, width of each channel half-period register.
REQ-003 SHALL provide parameter VOL_W, default 4, width of each channel volume register.
REQ-004 SHALL provide parameter TICK_DIV, default 16, clocks per tone tick (>=2).
REQ-005 SHALL use derived width MIX_W = VOL_W + clog2(CHANNELS), minimum VOL_W+1.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-009 wr_addr  input  3  target channel index.
REQ-010 wr_period  input  PERIOD_W  new half-period for target channel.
REQ-011 wr_vol  input  VOL_W  new volume for target channel.
REQ-012 phase_out  output  CHANNELS  current square-wave phase per channel.
REQ-013 mix_out  output  MIX_W  latched mix sample driving the PWM.
REQ-014 pwm_out  output  1  PWM audio output.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick for one clk when it wraps to 0.
REQ-016 Each channel SHALL hold period, volume, down-counter and phase registers.
REQ-017 On tick, a channel with counter==0 SHALL reload counter from period and toggle phase; otherwise it decrements counter.
REQ-018 Phase toggle interval SHALL be (period+1) ticks; full tone period 2*(period+1)*TICK_DIV clks.
REQ-019 A channel with period==0 SHALL be silent: phase forced 0, counter held 0.
REQ-020 A write with wr_en=1 and wr_addr<CHANNELS SHALL update period and volume of that channel on the next edge and load counter with wr_period; phase unchanged unless REQ-019 applies.
REQ-021 Writes with wr_addr>=CHANNELS SHALL be ignored with no state change.
REQ-022 Write and tick reload on the same channel in the same cycle: write SHALL win.
REQ-023 Combinational mix SHALL be sum of volume over channels with phase=1, no saturation (MIX_W holds worst case).
REQ-024 PWM counter SHALL free-run 0..2^MIX_W-1; mix_out SHALL load the mix only in the cycle the PWM counter is 0 (glitch-free update).
REQ-025 pwm_out SHALL be registered, =1 when PWM counter < mix_out; mix_out=0 gives constant 0; duty = mix_out/2^MIX_W.
REQ-026 phase_out SHALL reflect registered phases directly, no extra latency.

Reset
REQ-027 While rst=1: prescaler, PWM counter, all periods, volumes, counters, phases, mix_out and pwm_out SHALL be 0.
REQ-028 Reset asserted mid-tone SHALL clear state immediately; first tick after release SHALL occur TICK_DIV clks after deassertion.
REQ-029 Writes while rst=1 SHALL be ignored.

Configuration
REQ-030 Macro TONE_MIXER_NOISE_EN, when defined, SHALL add a 15-bit LFSR (x^15+x^14+1, reset value 15'h4000) stepped at each channel-0 reload; channel-0 phase SHALL equal LFSR bit 0 after the step.
REQ-031 Without TONE_MIXER_NOISE_EN, channel 0 SHALL be an ordinary square channel and no LFSR logic SHALL exist.
REQ-032 Period==0 silencing of channel 0 SHALL apply in both builds; LFSR SHALL hold while silenced.

Verification (defaults: CHANNELS=4, PERIOD_W=12, VOL_W=4, TICK_DIV=16, MIX_W=6)
REQ-033 Reset, no writes -> phase_out=0, mix_out=0, pwm_out=0 for 1000 clks.
REQ-034 Write ch1 period=3 vol=15 -> phase_out[1] toggles every 64 clks; mix_out alternates 0/15; pwm_out high 15 of 64 clks while phase=1.
REQ-035 All four channels period=1 vol=15, same write cycle set -> mix_out reaches 60, pwm_out duty 60/64; no overflow.
REQ-036 Write wr_addr=5 -> no register, phase or mix change; write ch2 period=0 while toggling -> phase_out[2]=0 next clk and stays 0.
REQ-037 Assert rst mid-tone for 1 clk (asynchronous, off-edge) -> all outputs 0 before next edge; tones resume only after new writes.
REQ-038 With TONE_MIXER_NOISE_EN, ch0 period=0->1 -> phase_out[0] follows LFSR bit0 sequence from seed 15'h4000; without macro, regular square wave.
